// File: rtl/vid_timing_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vid_timing_detect                                                        |
// | Measures DE/HS/VS stream timing per frame, reports lock and format loss. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vid_timing_detect #(
  parameter int CW          = 12,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1048576,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_de,
  input  logic          vid_hs,
  input  logic          vid_vs,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] h_sync,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic [CW-1:0] v_sync,
  output logic          meas_valid,
  output logic          locked,
  output logic          fmt_change
);

  localparam logic [CW-1:0]   C_MAX     = '1;
  localparam int              C_TW      = $clog2(TIMEOUT + 1);
  localparam logic [C_TW-1:0] C_TO_MAX  = C_TW'(TIMEOUT);
  localparam logic [C_TW-1:0] C_TO_LAST = C_TW'(TIMEOUT - 1);
  localparam logic [3:0]      C_LOCK    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {IDLE, MEASURE, CHECK, LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == C_MAX) ? v : v + CW'(1);
  endfunction

  // polarity-normalised input registers and their delayed copies
  logic r_de, r_hs, r_vs, r_hs_d, r_vs_d;
  logic w_hs_le, w_vs_le;

  logic [CW-1:0] r_hcnt, r_hs_w, r_de_w;
  logic [CW-1:0] r_hper, r_hsw, r_hact;
  logic [CW-1:0] r_vcnt, r_vs_l, r_act_l;
  logic          r_sat_seen;
  logic [C_TW-1:0] r_to_cnt;

  logic [CW-1:0] w_hper_nxt, w_hsw_nxt, w_hact_nxt;
  logic [CW-1:0] w_vcnt_nxt, w_vsl_nxt, w_act_nxt;
  logic          w_line_de, w_run_sat, w_snap_sat, w_bad, w_equal, w_timeout;
  logic [6*CW-1:0] w_snap, w_meas;

  state_t        r_state;
  logic [3:0]    r_match;
  logic [CW-1:0] r_h_total, r_h_active, r_h_sync, r_v_total, r_v_active, r_v_sync;
  logic          r_meas_valid, r_locked, r_fmt_change;

  assign w_hs_le   = r_hs & ~r_hs_d;
  assign w_vs_le   = r_vs & ~r_vs_d;
  assign w_line_de = w_hs_le && (r_de_w != '0);

  // shadow values as they stand after this cycle's HS edge, so a coincident
  // HS edge is folded into the frame that the VS edge closes
  assign w_hper_nxt = w_hs_le   ? r_hcnt           : r_hper;
  assign w_hsw_nxt  = w_hs_le   ? r_hs_w           : r_hsw;
  assign w_hact_nxt = w_line_de ? r_de_w           : r_hact;
  assign w_vcnt_nxt = w_hs_le   ? sat_inc(r_vcnt)  : r_vcnt;
  assign w_vsl_nxt  = (w_hs_le && r_vs) ? sat_inc(r_vs_l) : r_vs_l;
  assign w_act_nxt  = w_line_de ? sat_inc(r_act_l) : r_act_l;

  assign w_snap = {w_hper_nxt, w_hact_nxt, w_hsw_nxt, w_vcnt_nxt, w_act_nxt, w_vsl_nxt};
  assign w_meas = {r_h_total, r_h_active, r_h_sync, r_v_total, r_v_active, r_v_sync};

  assign w_run_sat  = (r_hcnt == C_MAX) | (r_hs_w == C_MAX) | (r_de_w == C_MAX) |
                      (r_vcnt == C_MAX) | (r_vs_l == C_MAX) | (r_act_l == C_MAX);
  assign w_snap_sat = (w_hper_nxt == C_MAX) | (w_hsw_nxt == C_MAX) | (w_hact_nxt == C_MAX) |
                      (w_vcnt_nxt == C_MAX) | (w_vsl_nxt == C_MAX) | (w_act_nxt == C_MAX);
  assign w_bad      = r_sat_seen | w_run_sat | w_snap_sat;
  assign w_equal    = (w_snap == w_meas) && !w_bad;
  assign w_timeout  = !w_hs_le && (r_to_cnt == C_TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_de       <= 1'b0;
      r_hs       <= 1'b0;
      r_vs       <= 1'b0;
      r_hs_d     <= 1'b0;
      r_vs_d     <= 1'b0;
      r_hcnt     <= '0;
      r_hs_w     <= '0;
      r_de_w     <= '0;
      r_hper     <= '0;
      r_hsw      <= '0;
      r_hact     <= '0;
      r_vcnt     <= '0;
      r_vs_l     <= '0;
      r_act_l    <= '0;
      r_sat_seen <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      r_de   <= vid_de;
      r_hs   <= (vid_hs == HS_POL);
      r_vs   <= (vid_vs == VS_POL);
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;

      r_hcnt <= w_hs_le ? CW'(1) : sat_inc(r_hcnt);
      if (w_hs_le)   r_hs_w <= CW'(1);
      else if (r_hs) r_hs_w <= sat_inc(r_hs_w);
      if (w_hs_le)   r_de_w <= r_de ? CW'(1) : '0;
      else if (r_de) r_de_w <= sat_inc(r_de_w);

      r_hper <= w_hper_nxt;
      r_hsw  <= w_hsw_nxt;
      r_hact <= w_hact_nxt;

      if (w_vs_le) begin
        r_vcnt     <= '0;
        r_vs_l     <= '0;
        r_act_l    <= '0;
        r_sat_seen <= 1'b0;
      end else begin
        r_vcnt     <= w_vcnt_nxt;
        r_vs_l     <= w_vsl_nxt;
        r_act_l    <= w_act_nxt;
        r_sat_seen <= r_sat_seen | w_run_sat;
      end

      if (w_hs_le)                    r_to_cnt <= '0;
      else if (r_to_cnt != C_TO_MAX)  r_to_cnt <= r_to_cnt + C_TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_match      <= '0;
      r_h_total    <= '0;
      r_h_active   <= '0;
      r_h_sync     <= '0;
      r_v_total    <= '0;
      r_v_active   <= '0;
      r_v_sync     <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_fmt_change <= 1'b0;
    end else begin
      r_fmt_change <= 1'b0;
      if (w_timeout) begin
        r_state      <= IDLE;
        r_match      <= '0;
        {r_h_total, r_h_active, r_h_sync, r_v_total, r_v_active, r_v_sync} <= '0;
        r_meas_valid <= 1'b0;
        r_locked     <= 1'b0;
      end else if (w_vs_le) begin
        case (r_state)
          IDLE: r_state <= MEASURE;
          MEASURE: begin
            {r_h_total, r_h_active, r_h_sync, r_v_total, r_v_active, r_v_sync} <= w_snap;
            r_meas_valid <= 1'b1;
            r_match      <= 4'd1;
            if (LOCK_FRAMES == 1 && !w_bad) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state  <= CHECK;
            end
          end
          CHECK: begin
            {r_h_total, r_h_active, r_h_sync, r_v_total, r_v_active, r_v_sync} <= w_snap;
            if (w_equal) begin
              r_match <= r_match + 4'd1;
              if ((r_match + 4'd1) >= C_LOCK) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_match <= 4'd1;
            end
          end
          LOCKED: begin
            {r_h_total, r_h_active, r_h_sync, r_v_total, r_v_active, r_v_sync} <= w_snap;
            if (!w_equal) begin
              r_state      <= CHECK;
              r_locked     <= 1'b0;
              r_fmt_change <= 1'b1;
              r_match      <= 4'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign h_total    = r_h_total;
  assign h_active   = r_h_active;
  assign h_sync     = r_h_sync;
  assign v_total    = r_v_total;
  assign v_active   = r_v_active;
  assign v_sync     = r_v_sync;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign fmt_change = r_fmt_change;

endmodule
`default_nettype wire

// File: tb/tb_vid_timing_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vid_timing_detect                                                     |
// | Random-format stream against a frame-level lock model, both polarities.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vid_timing_detect;

  localparam int CW        = 12;
  localparam int LF        = 2;
  localparam int TO        = 6000;
  localparam int LONG_LINE = 5000;
  localparam int MAXV      = (1 << CW) - 1;

  typedef struct packed {
    int ht; int hs; int ha; int vt; int vs; int va;
  } fmt_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic de = 1'b0, hs_a = 1'b0, vs_a = 1'b0, hs_b = 1'b1, vs_b = 1'b1;

  logic [CW-1:0] ht_a, ha_a, hsy_a, vt_a, va_a, vsy_a;
  logic [CW-1:0] ht_b, ha_b, hsy_b, vt_b, va_b, vsy_b;
  logic mv_a, lk_a, fc_a, mv_b, lk_b, fc_b;

  vid_timing_detect #(.CW(CW), .LOCK_FRAMES(LF), .TIMEOUT(TO), .HS_POL(1'b1), .VS_POL(1'b1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .vid_de(de), .vid_hs(hs_a), .vid_vs(vs_a),
    .h_total(ht_a), .h_active(ha_a), .h_sync(hsy_a), .v_total(vt_a), .v_active(va_a),
    .v_sync(vsy_a), .meas_valid(mv_a), .locked(lk_a), .fmt_change(fc_a));

  vid_timing_detect #(.CW(CW), .LOCK_FRAMES(LF), .TIMEOUT(TO), .HS_POL(1'b0), .VS_POL(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .vid_de(de), .vid_hs(hs_b), .vid_vs(vs_b),
    .h_total(ht_b), .h_active(ha_b), .h_sync(hsy_b), .v_total(vt_b), .v_active(va_b),
    .v_sync(vsy_b), .meas_valid(mv_b), .locked(lk_b), .fmt_change(fc_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fcn_a    = 0;
  int fcn_b    = 0;

  // every high cycle of fmt_change counts, so a stretched pulse is visible
  always @(posedge clk) begin
    if (fc_a) fcn_a <= fcn_a + 1;
    if (fc_b) fcn_b <= fcn_b + 1;
  end

  // frame-level reference: expected outputs, streak of identical good frames
  int   bnd;
  int   streak;
  int   fc_exp;
  bit   exp_lock;
  bit   exp_valid;
  fmt_t exp_out;
  fmt_t prev_fmt;
  bit   prev_long;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_clear();
    bnd       = 0;
    streak    = 0;
    exp_lock  = 1'b0;
    exp_valid = 1'b0;
    exp_out   = '0;
  endtask

  task automatic model_boundary();
    fmt_t m;
    bit   bad;
    bnd++;
    if (bnd >= 2) begin
      m = prev_fmt;
      if (prev_long) m.ht = (LONG_LINE > MAXV) ? MAXV : LONG_LINE;
      bad = (m.ht >= MAXV) || (m.hs >= MAXV) || (m.ha >= MAXV) ||
            (m.vt >= MAXV) || (m.vs >= MAXV) || (m.va >= MAXV);
      if (bad)                             streak = 0;
      else if (bnd >= 3 && m == exp_out)   streak++;
      else                                 streak = 1;
      exp_out   = m;
      exp_valid = 1'b1;
      if (exp_lock && streak < LF) fc_exp++;
      exp_lock  = (streak >= LF);
    end
  endtask

  task automatic check_dut(input string tag, input int ht, input int ha, input int hsy,
                           input int vt, input int va, input int vsy,
                           input int mv, input int lk, input int fcn);
    check({tag, ".h_total"},    ht,  exp_out.ht);
    check({tag, ".h_active"},   ha,  exp_out.ha);
    check({tag, ".h_sync"},     hsy, exp_out.hs);
    check({tag, ".v_total"},    vt,  exp_out.vt);
    check({tag, ".v_active"},   va,  exp_out.va);
    check({tag, ".v_sync"},     vsy, exp_out.vs);
    check({tag, ".meas_valid"}, mv,  int'(exp_valid));
    check({tag, ".locked"},     lk,  int'(exp_lock));
    check({tag, ".fmt_change"}, fcn, fc_exp);
  endtask

  task automatic check_all(input string tag);
    check_dut({tag, ".pos"}, int'(ht_a), int'(ha_a), int'(hsy_a), int'(vt_a), int'(va_a),
              int'(vsy_a), int'(mv_a), int'(lk_a), fcn_a);
    check_dut({tag, ".neg"}, int'(ht_b), int'(ha_b), int'(hsy_b), int'(vt_b), int'(va_b),
              int'(vsy_b), int'(mv_b), int'(lk_b), fcn_b);
  endtask

  function automatic fmt_t rand_fmt();
    fmt_t f;
    f.ht = int'($urandom_range(90, 40));
    f.hs = int'($urandom_range(8, 2));
    f.ha = int'($urandom_range(f.ht - f.hs - 4, 10));
    f.vt = int'($urandom_range(20, 10));
    f.vs = int'($urandom_range(3, 1));
    f.va = int'($urandom_range(f.vt - f.vs - 2, 3));
    return f;
  endfunction

  task automatic run_frame(input fmt_t f, input bit lng, input bit rst_mid);
    int hbp, vbp, len;
    bit h_on, v_on;
    hbp = (f.ht - f.hs - f.ha) / 2;
    vbp = (f.vt - f.vs - f.va) / 2;
    for (int l = 0; l < f.vt; l++) begin
      len = (lng && l == f.vt - 1) ? LONG_LINE : f.ht;
      for (int p = 0; p < len; p++) begin
        @(posedge clk);
        h_on = (p < f.hs);
        v_on = (l < f.vs);
        hs_a = h_on;  hs_b = ~h_on;
        vs_a = v_on;  vs_b = ~v_on;
        de   = (l >= f.vs + vbp) && (l < f.vs + vbp + f.va) &&
               (p >= f.hs + hbp) && (p < f.hs + hbp + f.ha);
        if (l == 0 && p == 0) model_boundary();
        if (l == 0 && p == 3) begin
          @(negedge clk);
          check_all($sformatf("bnd%0d", bnd));
        end
        if (rst_mid && l == f.vt / 2 && p == 0) begin
          #2 reset_n = 1'b0;
          #1 model_clear();
          check_all("async_reset");
          @(negedge clk);
          reset_n = 1'b1;
        end
      end
    end
    prev_fmt  = f;
    prev_long = lng;
  endtask

  // syncs frozen after a frame; i counts clocks since the last HS edge was driven
  task automatic hold_timeout(input fmt_t f);
    de = 1'b0;
    for (int i = f.ht; i <= TO + 3; i++) begin
      @(posedge clk);
      if (i == TO - 3) begin
        @(negedge clk);
        check("pre_timeout.locked.pos", int'(lk_a), int'(exp_lock));
        check("pre_timeout.locked.neg", int'(lk_b), int'(exp_lock));
      end
    end
    @(negedge clk);
    model_clear();
    check_all("timeout");
  endtask

  initial begin
    fmt_t f1, f2;
    model_clear();
    fc_exp    = 0;
    prev_fmt  = '0;
    prev_long = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;

    f1 = rand_fmt();
    do f2 = rand_fmt(); while (f2.ht == f1.ht);

    repeat (4) run_frame(f1, 1'b0, 1'b0);
    repeat (3) run_frame(f2, 1'b0, 1'b0);
    hold_timeout(f2);

    run_frame(f2, 1'b0, 1'b0);
    run_frame(f2, 1'b1, 1'b0);
    run_frame(f2, 1'b0, 1'b0);
    run_frame(f2, 1'b0, 1'b0);
    run_frame(f2, 1'b0, 1'b1);
    repeat (3) run_frame(f2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
